// File: rtl/fir_mac_sequencer_if.sv
// Bus bundle between the FIR MAC sequencer and its sample source, sample RAM,
// coefficient ROM, MAC datapath and result consumer.
// master: the sequencer side (drives s_ready, RAM/ROM addresses, MAC strobes,
//         y_valid, busy; receives s_valid, s_data, y_ready).
// slave:  the surrounding system side (mirror image of master).
// FIR_SYMM_EN adds smp_raddr_b, the mirrored-tap sample read address.
interface fir_mac_sequencer_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
);
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;
    logic                     smp_we;
    logic [ADDR_W-1:0]        smp_waddr;
    logic signed [DATA_W-1:0] smp_wdata;
    logic [ADDR_W-1:0]        smp_raddr;
`ifdef FIR_SYMM_EN
    logic [ADDR_W-1:0]        smp_raddr_b;
`endif
    logic [ADDR_W-1:0]        coef_raddr;
    logic                     mac_clr;
    logic                     mac_en;
    logic                     mac_last;
    logic                     y_valid;
    logic                     y_ready;
    logic                     busy;

    modport master (
        input  s_valid, s_data, y_ready,
        output s_ready, smp_we, smp_waddr, smp_wdata, smp_raddr,
`ifdef FIR_SYMM_EN
        output smp_raddr_b,
`endif
        output coef_raddr, mac_clr, mac_en, mac_last, y_valid, busy
    );

    modport slave (
        output s_valid, s_data, y_ready,
        input  s_ready, smp_we, smp_waddr, smp_wdata, smp_raddr,
`ifdef FIR_SYMM_EN
        input  smp_raddr_b,
`endif
        input  coef_raddr, mac_clr, mac_en, mac_last, y_valid, busy
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Folded single-MAC FIR controller: clears the circular sample RAM, accepts
// one sample per handshake, walks the taps one per cycle, waits out the MAC
// pipeline and offers the result with a valid/ready handshake.
// Ports: clk, reset (async, active-high), bus (fir_mac_sequencer_if.master).
// Optional macro FIR_SYMM_EN: symmetric-coefficient folding (half-length RUN,
// second read address smp_raddr_b); N_TAPS must then be even.
module fir_mac_sequencer #(
    parameter int N_TAPS  = 100,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 32,
    parameter int MAC_LAT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    fir_mac_sequencer_if.master   bus
);

`ifdef FIR_SYMM_EN
    localparam int RUN_N = N_TAPS / 2;
    if (N_TAPS % 2 != 0) begin : g_odd_taps
        $error("fir_mac_sequencer: FIR_SYMM_EN needs an even N_TAPS");
    end
`else
    localparam int RUN_N = N_TAPS;
`endif

    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [DW-1:0]     D_LAST = DW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(N_TAPS - 1);
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(RUN_N - 1);
    localparam logic [ADDR_W:0]   N_EXT  = (ADDR_W + 1)'(N_TAPS);

    typedef enum logic [2:0] {CLEAR, IDLE, RUN, DRAIN, OUT} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] k, k_nx;
    logic [ADDR_W-1:0] wptr, wptr_nx;
    logic [ADDR_W-1:0] newest, newest_nx;
    logic [DW-1:0]     d, d_nx;

    // (nw - j) mod N_TAPS; wraps by adding N_TAPS, not by 2^ADDR_W overflow.
    function automatic logic [ADDR_W-1:0] tap_addr(
        input logic [ADDR_W-1:0] nw,
        input logic [ADDR_W-1:0] j
    );
        if (nw >= j)
            return nw - j;
        return ADDR_W'(N_EXT - {1'b0, j} + {1'b0, nw});
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= CLEAR;
            k      <= '0;
            wptr   <= '0;
            newest <= '0;
            d      <= '0;
        end else begin
            state  <= state_nx;
            k      <= k_nx;
            wptr   <= wptr_nx;
            newest <= newest_nx;
            d      <= d_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        k_nx           = k;
        wptr_nx        = wptr;
        newest_nx      = newest;
        d_nx           = d;
        bus.s_ready    = 1'b0;
        bus.smp_we     = 1'b0;
        bus.smp_waddr  = '0;
        bus.smp_wdata  = '0;
        bus.smp_raddr  = '0;
`ifdef FIR_SYMM_EN
        bus.smp_raddr_b = '0;
`endif
        bus.coef_raddr = '0;
        bus.mac_clr    = 1'b0;
        bus.mac_en     = 1'b0;
        bus.mac_last   = 1'b0;
        bus.y_valid    = 1'b0;
        bus.busy       = (state != IDLE);

        unique case (state)
            CLEAR: begin
                bus.smp_we    = 1'b1;
                bus.smp_waddr = k;
                if (k == A_LAST) begin
                    k_nx     = '0;
                    state_nx = IDLE;
                end else begin
                    k_nx = k + 1'b1;
                end
            end
            IDLE: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    bus.smp_we    = 1'b1;
                    bus.smp_waddr = wptr;
                    bus.smp_wdata = bus.s_data;
                    newest_nx     = wptr;
                    wptr_nx       = (wptr == A_LAST) ? '0 : wptr + 1'b1;
                    k_nx          = '0;
                    state_nx      = RUN;
                end
            end
            RUN: begin
                bus.mac_en     = 1'b1;
                bus.coef_raddr = k;
                bus.smp_raddr  = tap_addr(newest, k);
`ifdef FIR_SYMM_EN
                bus.smp_raddr_b = tap_addr(newest, A_LAST - k);
`endif
                bus.mac_clr    = (k == '0);
                bus.mac_last   = (k == K_LAST);
                if (k == K_LAST) begin
                    k_nx     = '0;
                    d_nx     = '0;
                    state_nx = (MAC_LAT == 0) ? OUT : DRAIN;
                end else begin
                    k_nx = k + 1'b1;
                end
            end
            DRAIN: begin
                if (d == D_LAST)
                    state_nx = OUT;
                else
                    d_nx = d + 1'b1;
            end
            OUT: begin
                bus.y_valid = 1'b1;
                if (bus.y_ready)
                    state_nx = IDLE;
            end
            default: state_nx = CLEAR;
        endcase

        // Reset forces every output low at once, independent of the clock.
        if (reset) begin
            bus.s_ready    = 1'b0;
            bus.smp_we     = 1'b0;
            bus.smp_waddr  = '0;
            bus.smp_wdata  = '0;
            bus.smp_raddr  = '0;
`ifdef FIR_SYMM_EN
            bus.smp_raddr_b = '0;
`endif
            bus.coef_raddr = '0;
            bus.mac_clr    = 1'b0;
            bus.mac_en     = 1'b0;
            bus.mac_last   = 1'b0;
            bus.y_valid    = 1'b0;
            bus.busy       = 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed self-checking bench for fir_mac_sequencer (N_TAPS=100, MAC_LAT=2).
// Ports: none; drives the DUT through a fir_mac_sequencer_if instance.
module tb_fir_mac_sequencer;
    localparam int N  = 100;
    localparam int AW = 7;
    localparam int DW = 32;
    localparam int ML = 2;
`ifdef FIR_SYMM_EN
    localparam int RUN_N = N / 2;
`else
    localparam int RUN_N = N;
`endif

    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;
    int   wm   = 0;
    int   nw_m = 0;

    fir_mac_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fir_mac_sequencer #(
        .N_TAPS(N), .ADDR_W(AW), .DATA_W(DW), .MAC_LAT(ML)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_check();
        for (int i = 0; i < N; i++) begin
            #1;
            chk("clear", {bus.smp_we, bus.smp_waddr, bus.smp_wdata,
                          bus.s_ready, bus.y_valid},
                {1'b1, AW'(i), DW'(0), 1'b0, 1'b0});
            tick();
        end
        #1;
        chk("idle", {bus.s_ready, bus.smp_we, bus.busy}, 3'b100);
    endtask

    task automatic send(input logic [DW-1:0] v);
        int n = 0;
        while (!bus.s_ready && n < 400) begin
            tick();
            n++;
        end
        chk("ready_wait", bus.s_ready, 1);
        bus.s_valid = 1'b1;
        bus.s_data  = v;
        #1;
        chk("accept", {bus.smp_we, bus.smp_waddr, bus.smp_wdata},
            {1'b1, AW'(wm), v});
        nw_m = wm;
        wm   = (wm == N - 1) ? 0 : wm + 1;
        tick();
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
    endtask

    task automatic run_check();
        for (int k = 0; k < RUN_N; k++) begin
            #1;
            chk("run", {bus.mac_en, bus.mac_clr, bus.mac_last,
                        bus.coef_raddr, bus.smp_raddr, bus.s_ready},
                {1'b1, 1'(k == 0), 1'(k == RUN_N - 1), AW'(k),
                 AW'((nw_m - k + N) % N), 1'b0});
`ifdef FIR_SYMM_EN
            chk("run_b", bus.smp_raddr_b,
                AW'((nw_m - (N - 1 - k) + N) % N));
`endif
            tick();
        end
    endtask

    task automatic drain_check();
        for (int j = 0; j < ML; j++) begin
            #1;
            chk("drain", {bus.mac_en, bus.mac_clr, bus.mac_last,
                          bus.y_valid, bus.busy}, 5'b00001);
            tick();
        end
        #1;
        chk("out", {bus.y_valid, bus.busy, bus.s_ready}, 3'b110);
    endtask

    task automatic wait_out();
        int n = 0;
        while (!bus.y_valid && n < RUN_N + ML + 8) begin
            tick();
            n++;
        end
        chk("yvalid_wait", bus.y_valid, 1);
    endtask

    initial begin
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.y_ready = 1'b0;
        repeat (3) tick();
        chk("in_reset", {bus.smp_we, bus.s_ready, bus.y_valid,
                         bus.mac_en, bus.busy}, 0);
        reset = 1'b0;
        clear_check();

        // First sample: full RUN/DRAIN/OUT timing.
        bus.y_ready = 1'b1;
        send(32'h0000_0005);
        run_check();
        drain_check();
        tick();
        #1;
        chk("y_drop", {bus.y_valid, bus.s_ready}, 2'b01);

        // Fill the ring; the 101st sample wraps to address 0.
        for (int s = 2; s <= 100; s++) begin
            send(DW'(s));
            wait_out();
            tick();
        end
        send(32'hFFFF_FF9B);
        run_check();
        drain_check();
        tick();

        // Backpressure in OUT; next write lands at address 1.
        bus.y_ready = 1'b0;
        send(32'h1234_5678);
        wait_out();
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h0000_0007;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("hold", {bus.y_valid, bus.s_ready, bus.smp_we}, 3'b100);
            tick();
        end
        bus.y_ready = 1'b1;
        #1;
        chk("release", bus.y_valid, 1);
        tick();
        #1;
        chk("after_out", {bus.y_valid, bus.s_ready}, 2'b01);
        send(32'h0000_0007);

        // Abort at tap 40.
        repeat (40) tick();
        #1;
        chk("tap40", {bus.mac_en, bus.coef_raddr}, {1'b1, AW'(40)});
        reset = 1'b1;
        #1;
        chk("abort", {bus.smp_we, bus.mac_en, bus.mac_clr, bus.mac_last,
                      bus.y_valid, bus.s_ready, bus.busy,
                      bus.coef_raddr, bus.smp_raddr, bus.smp_waddr}, 0);
        tick();
        reset = 1'b0;
        wm    = 0;
        clear_check();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
